ofm_writer: RTL

OFM_WRITER -- requirements
Module: ofm_writer

---
 rtl/ofm_writer_pkg.sv | 36 +++
 rtl/ofm_packer.sv | 52 +++++
 rtl/ofm_writer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ofm_writer_pkg.sv
// ---------------------------------------------------------------------------
// ofm_writer_pkg
//
// Shared definitions for the output-feature-map writer:
//   - memory word / address geometry and pixel width
//   - job-length related widths
//   - FSM state encoding
//   - helper: number of 32-bit words needed to hold a filter's pixels
// ---------------------------------------------------------------------------
package ofm_writer_pkg;

  localparam int MEM_ADDR_W   = 10;
  localparam int MEM_DATA_W   = 32;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;

  // Pixel count per filter (ofm_len) and derived widths.
  localparam int LEN_W   = 8;
  localparam int LANE_W  = $clog2(PIX_PER_WORD);
  localparam int WORDS_W = LEN_W + 1 - LANE_W;  // holds ceil(255/4) = 64

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // ceil(len / PIX_PER_WORD): words occupied by one filter's output row.
  function automatic logic [WORDS_W-1:0] words_for_len(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W + 1)'(PIX_PER_WORD - 1);
    return sum[LEN_W:LANE_W];
  endfunction

endpackage

// File: rtl/ofm_packer.sv
// ---------------------------------------------------------------------------
// ofm_packer
//
// Collects 8-bit pixels of one filter into a 32-bit word. Pixel k lands in
// byte lane k mod 4 (first pixel in bits [7:0]). Lanes not written since the
// last clear stay 0x00, so a partial final word is zero-padded for free.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : write pix into byte lane `lane`
//   lane     : target byte lane (0..3)
//   pix      : pixel value
//   clr      : clear the whole word (has priority over wr_en)
//   word     : current packed word
// ---------------------------------------------------------------------------
module ofm_packer
  import ofm_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [LANE_W-1:0]     lane,
  input  logic [PIX_W-1:0]      pix,
  input  logic                  clr,
  output logic [MEM_DATA_W-1:0] word
);

  logic [MEM_DATA_W-1:0] word_q;
  logic [MEM_DATA_W-1:0] word_d;

  // NOTE: word_d gets a full default before any branch, so no path through this block infers a latch.
  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (wr_en) begin
      word_d[lane*PIX_W +: PIX_W] = pix;
    end
  end

  // NOTE: the pack register is reset, so a job aborted by rst cannot leak stale lanes into the next job's partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/ofm_writer.sv
// ---------------------------------------------------------------------------
// ofm_writer
//
// Writes the results of N PEs (one pixel per filter per transfer) back to a
// 32-bit-wide memory. Pixels of each filter are packed four to a word; once
// a word is full (or the row ends) the N packed words are written out on N
// consecutive cycles, filter 0 first. Filter f, word w goes to
// base_addr + f*W + w (mod 1024), W = ceil(ofm_len/4).
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle job start pulse, honoured only when idle
//   base_addr   : first word address of the job (sampled on start)
//   ofm_len     : pixels per filter (sampled on start); 0 completes at once
//   pe_valid    : pe_data carries a valid result vector
//   pe_data     : N pixels, filter f in bits [8f+7:8f]
//   pe_ready    : writer consumes pe_data this cycle when pe_valid is high
//   mem_wen     : memory write strobe
//   mem_addr    : memory word address (0 when mem_wen is low)
//   mem_wdata   : memory write data  (0 when mem_wen is low)
//   busy        : job in progress
//   done        : one-cycle pulse at job completion
// ---------------------------------------------------------------------------
module ofm_writer
  import ofm_writer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]      ofm_len,
  input  logic                  pe_valid,
  input  logic [PIX_W*N-1:0]    pe_data,
  output logic                  pe_ready,
  output logic                  mem_wen,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int              FC_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [FC_W-1:0] LAST_F = FC_W'(N - 1);

  // Job registers
  state_e                state_q;
  logic [MEM_ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]      len_q;
  logic [WORDS_W-1:0]    words_q;     // W: words per filter
  logic [LEN_W-1:0]      pix_idx_q;   // pixels consumed so far
  logic [WORDS_W-1:0]    word_idx_q;  // word column being filled
  logic [FC_W-1:0]       flush_f_q;   // filter being written during FLUSH
  logic [MEM_ADDR_W-1:0] addr_q;      // address of the current FLUSH write

  // Registered outputs
  logic pe_ready_q;
  logic mem_wen_q;
  logic busy_q;
  logic done_q;

  // Transfer decode
  logic                  xfer;
  logic [LANE_W-1:0]     lane;
  logic                  word_full;
  logic                  last_pix;
  logic [LEN_W-1:0]      pix_idx_d;
  logic [MEM_ADDR_W-1:0] flush_addr_d;

  assign xfer      = pe_ready_q && pe_valid;
  assign lane      = pix_idx_q[LANE_W-1:0];
  assign word_full = (lane == '1);
  assign last_pix  = (pix_idx_q == len_q - LEN_W'(1));
  assign pix_idx_d = pix_idx_q + LEN_W'(1);
  // First write of a flush is filter 0 at column word_idx; later filters step by W.
  assign flush_addr_d = base_q + MEM_ADDR_W'(word_idx_q);

  // Per-filter pack registers
  logic [N-1:0]          clr_vec;
  logic [MEM_DATA_W-1:0] pack_word [N];

  for (genvar f = 0; f < N; f++) begin : g_pack
    // A word is cleared in the same cycle it is written out.
    assign clr_vec[f] = mem_wen_q && (flush_f_q == FC_W'(f));

    ofm_packer u_packer (
      .clk   (clk),
      .rst   (rst),
      .wr_en (xfer),
      .lane  (lane),
      .pix   (pe_data[f*PIX_W +: PIX_W]),
      .clr   (clr_vec[f]),
      .word  (pack_word[f])
    );
  end

  // Write-data select; zero whenever no write is in progress.
  always_comb begin
    mem_wdata = '0;
    for (int f = 0; f < N; f++) begin
      if (clr_vec[f]) mem_wdata = pack_word[f];
    end
  end

  assign mem_addr = mem_wen_q ? addr_q : '0;
  assign pe_ready = pe_ready_q;
  assign mem_wen  = mem_wen_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Control FSM with registered outputs.
  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      words_q    <= '0;
      pix_idx_q  <= '0;
      word_idx_q <= '0;
      flush_f_q  <= '0;
      addr_q     <= '0;
      pe_ready_q <= 1'b0;
      mem_wen_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            len_q      <= ofm_len;
            words_q    <= words_for_len(ofm_len);
            pix_idx_q  <= '0;
            word_idx_q <= '0;
            if (ofm_len == '0) begin
              // Empty job: nothing to accept, report completion directly.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_ACCEPT;
              pe_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end

        ST_ACCEPT: begin
          if (xfer) begin
            pix_idx_q <= pix_idx_d;
            if (word_full || last_pix) begin
              state_q    <= ST_FLUSH;
              pe_ready_q <= 1'b0;
              mem_wen_q  <= 1'b1;
              flush_f_q  <= '0;
              addr_q     <= flush_addr_d;
            end
          end
        end

        ST_FLUSH: begin
          if (flush_f_q == LAST_F) begin
            mem_wen_q  <= 1'b0;
            flush_f_q  <= '0;
            addr_q     <= '0;
            word_idx_q <= word_idx_q + WORDS_W'(1);
            if (pix_idx_q < len_q) begin
              state_q    <= ST_ACCEPT;
              pe_ready_q <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            flush_f_q <= flush_f_q + FC_W'(1);
            addr_q    <= addr_q + MEM_ADDR_W'(words_q);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
